// File: rtl/mult_ctrl_pkg.sv
// Shared constants for the multiplier-sharing controller: FSM encoding,
// default operand width and the settle-counter width.
package mult_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned DEF_WIDTH = 4;
  // Settle counter holds CALC_CYCLES-1, and CALC_CYCLES tops out at 15
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/array_mult_core.sv
// Combinational WIDTHxWIDTH unsigned AND-array multiplier: the partial-product
// rows (a AND b[i]) are shifted into place and summed. There is no clock.
module array_mult_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + (PW'(a & {WIDTH{b[i]}}) << i);
    end
    p_c = acc;
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer that shares one combinational array multiplier
// between two valid/ready requesters and returns tagged products.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_p,
  output logic               rsp_id,
  output logic               busy,
  output logic [7:0]         op_count
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [PW-1:0]    prod_c;
  logic             grant_id;
  logic             accept;

  // The only multiplier instance; it sees nothing but the held operand regs
  array_mult_core #(.WIDTH(WIDTH)) u_core (
    .a   (op_a),
    .b   (op_b),
    .p_c (prod_c)
  );

  assign busy = (state != ST_IDLE);

  // Grant selection and next state; the grant is re-evaluated every IDLE cycle
  always_comb begin
    req_ready = 2'b00;
    state_nxt = state;
    grant_id  = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    if (state == ST_IDLE && !rst && (req_valid != 2'b00)) begin
      req_ready[grant_id] = 1'b1;
    end
    accept = |(req_valid & req_ready);
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_valid && rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, settle count and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a   <= grant_id ? req1_a : req0_a;
            op_b   <= grant_id ? req1_b : req0_b;
            rsp_id <= grant_id;
            rr_ptr <= ~grant_id;
            cnt    <= CNT_W'(CALC_CYCLES - 1);
          end
        end
        ST_CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_p     <= prod_c;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
